// File: rtl/complete_multiplier.sv
//------------------------------------------------------------------------------
// complete_multiplier: digit-serial GF(2) polynomial multiplier, W = clmul(U,V) << 1.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module complete_multiplier #(
  parameter int N = 17669,
  parameter int D = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   U,
  input  logic [N-1:0]   V,
  output logic [2*N-1:0] W,
  output logic           done
);

  localparam int K  = (N + D - 1) / D;
  localparam int KD = K * D;
  localparam int PW = 2 * N - 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    u_reg;
  logic [KD-1:0]   v_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [D-1:0]    digit;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   next_acc;

  // Horner evaluation from the most significant digit: acc = acc*x^D + U*digit.
  always_comb begin
    digit   = v_reg[KD-1 -: D];
    partial = '0;
    for (int i = 0; i < D; i++) begin
      if (digit[i]) begin
        partial = partial ^ (PW'(u_reg) << i);
      end
    end
    next_acc = (acc << D) ^ partial;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      u_reg <= '0;
      v_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      W     <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          u_reg <= U;
          v_reg <= KD'(V);
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc   <= next_acc;
          v_reg <= v_reg << D;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(K - 1)) begin
            W     <= {next_acc, 1'b0};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_complete_multiplier.sv
//------------------------------------------------------------------------------
// tb_complete_multiplier: randomized scoreboard bench for complete_multiplier.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_complete_multiplier;

  localparam int N = 17669;
  localparam int D = 64;
  localparam int K = (N + D - 1) / D;
  localparam int WW = 2 * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  U = '0;
  logic [N-1:0]  V = '0;
  logic [WW-1:0] W;
  logic          done;

  int checks = 0;
  int fails  = 0;
  logic [WW-1:0] exp_q[$];

  complete_multiplier #(.N(N), .D(D)) dut (
    .clk(clk), .reset(reset), .U(U), .V(V), .W(W), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
    int first;
    checks++;
    if (act !== expv) begin
      fails++;
      first = -1;
      for (int i = 0; i < WW; i++) begin
        if (first < 0 && act[i] !== expv[i]) first = i;
      end
      $display("FAIL %s: first differing bit %0d, got low64=%h required low64=%h (got bit=%b required bit=%b)",
               name, first, act[63:0], expv[63:0], act[first], expv[first]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  // Bit-serial reference: XOR V shifted by every set bit position of U.
  function automatic logic [WW-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) r = r ^ (WW'(b) << i);
    end
    return r << 1;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Monitor: checks reset behaviour, done timing, product and hold.
  initial begin : monitor
    int since;
    logic prev_done;
    logic [WW-1:0] held;
    since = 0;
    prev_done = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        since = 0;
        check_int("done_in_reset", int'(done), 0);
        check_vec("w_in_reset", W, '0);
        prev_done = 1'b0;
      end else begin
        since++;
        if (prev_done) begin
          check_int("done_hold", int'(done), 1);
          check_vec("w_hold", W, held);
        end else if (done) begin
          check_int("done_edge", since, K + 1);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 required no pending result");
          end else begin
            check_vec("product", W, exp_q.pop_front());
          end
          held = W;
        end else begin
          check_vec("w_zero_before_done", W, '0);
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_done(input bit scramble);
    int n;
    n = 0;
    while (!done && n < K + 5) begin
      @(negedge clk);
      if (scramble) begin
        U = U ^ (N'($urandom) << $urandom_range(0, N - 1));
        V = V ^ (N'($urandom) << $urandom_range(0, N - 1));
      end
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got done=0 after %0d cycles required done=1", n);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [WW-1:0] expv, input bit scramble);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    U = a;
    V = b;
    exp_q.push_back(expv);
    reset = 1'b0;
    @(negedge clk);
    if (scramble) begin
      U = rand_vec();
      V = rand_vec();
    end
    wait_done(scramble);
    // Operand changes after completion must not disturb the held result.
    repeat (3) begin
      @(negedge clk);
      U = U ^ (N'($urandom) << $urandom_range(0, N - 1));
      V = V ^ (N'($urandom) << $urandom_range(0, N - 1));
    end
  endtask

  initial begin : driver
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [WW-1:0] e;
    logic [95:0]   big;
    int m;

    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_mult(N'(1), N'(1), WW'(2), 1'b0);
    run_mult(N'(3), N'(3), WW'(10), 1'b0);
    run_mult('0, rand_vec(), '0, 1'b0);

    a = '0;
    a[N-1] = 1'b1;
    e = '0;
    e[WW-1] = 1'b1;
    run_mult(a, a, e, 1'b0);

    e = '0;
    for (int k = 0; k <= 2 * N - 2; k++) begin
      m = (k < 2 * N - 2 - k) ? k : 2 * N - 2 - k;
      e[k+1] = 1'((m + 1) % 2);
    end
    run_mult('1, '1, e, 1'b0);

    big = 96'd4892378128957813477589134;
    a = N'(big);
    big = 96'd2398457699321345184592348;
    b = N'(big);
    run_mult(a, b, ref_mul(a, b), 1'b0);

    run_mult(N'(1), N'(1), WW'(2), 1'b1);

    // Abort mid-run: the first multiplication must never report a result.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    U = N'(1);
    V = N'(1);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_int("done_mid_run", int'(done), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    U = N'(3);
    V = N'(3);
    exp_q.push_back(WW'(10));
    reset = 1'b0;
    wait_done(1'b0);
    repeat (3) @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      a = rand_vec();
      b = rand_vec();
      run_mult(a, b, ref_mul(a, b), 1'b0);
    end

    check_int("queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
